// File: rtl/unified_mem_arbiter.sv
// Arbiter that shares one single-port memory between instruction fetch and data
// access, sequencing both with a small FSM and generating the pipeline freeze.
module unified_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              dm_read,
  input  logic              dm_write,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] if_rdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              pipe_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_FETCH
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t              r_state;
  state_t              w_state_next;
  logic                r_mem_req;
  logic                w_mem_req_next;
  logic                r_mem_we;
  logic                w_mem_we_next;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [ADDR_W-1:0]   w_mem_addr_next;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [DATA_W-1:0]   w_mem_wdata_next;
  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   w_if_rdata_next;
  logic [DATA_W-1:0]   r_dm_rdata;
  logic [DATA_W-1:0]   w_dm_rdata_next;
  logic                r_if_done;
  logic                w_if_done_next;
  logic                r_dm_done;
  logic                w_dm_done_next;
  logic [CNT_W-1:0]    r_stall_cnt;

  logic                w_dm_need;
  logic                w_advance;

  // The pipeline may move only once every access it needs has completed.
  assign w_dm_need = dm_read | dm_write;
  assign w_advance = (~w_dm_need | r_dm_done) & (~if_req | r_if_done);

  assign pipe_stall  = ~w_advance;
  assign pc_write    = w_advance;
  assign if_id_write = w_advance;

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign if_rdata  = r_if_rdata;
  assign dm_rdata  = r_dm_rdata;
  assign stall_cnt = r_stall_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
      r_if_done   <= 1'b0;
      r_dm_done   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_mem_req   <= w_mem_req_next;
      r_mem_we    <= w_mem_we_next;
      r_mem_addr  <= w_mem_addr_next;
      r_mem_wdata <= w_mem_wdata_next;
      r_if_rdata  <= w_if_rdata_next;
      r_dm_rdata  <= w_dm_rdata_next;
      r_if_done   <= w_if_done_next;
      r_dm_done   <= w_dm_done_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_mem_req_next   = r_mem_req;
    w_mem_we_next    = r_mem_we;
    w_mem_addr_next  = r_mem_addr;
    w_mem_wdata_next = r_mem_wdata;
    w_if_rdata_next  = r_if_rdata;
    w_dm_rdata_next  = r_dm_rdata;
    // Completion flags belong to the current instruction and drop as it advances.
    w_if_done_next   = r_if_done & ~w_advance;
    w_dm_done_next   = r_dm_done & ~w_advance;

    unique case (r_state)
      S_IDLE: begin
        // Data first: the instruction in MEM is older than the one being fetched.
        if (w_dm_need && !r_dm_done) begin
          w_state_next     = S_DATA;
          w_mem_req_next   = 1'b1;
          w_mem_we_next    = dm_write;
          w_mem_addr_next  = dm_addr;
          w_mem_wdata_next = dm_wdata;
        end else if (if_req && !r_if_done && !w_advance) begin
          w_state_next    = S_FETCH;
          w_mem_req_next  = 1'b1;
          w_mem_we_next   = 1'b0;
          w_mem_addr_next = if_addr;
        end else begin
          w_mem_req_next = 1'b0;
          w_mem_we_next  = 1'b0;
        end
      end

      S_DATA: begin
        if (mem_ack) begin
          w_dm_done_next = 1'b1;
          if (!r_mem_we) begin
            w_dm_rdata_next = mem_rdata;
          end
          if (if_req && !r_if_done) begin
            w_state_next    = S_FETCH;
            w_mem_req_next  = 1'b1;
            w_mem_we_next   = 1'b0;
            w_mem_addr_next = if_addr;
          end else begin
            w_state_next   = S_IDLE;
            w_mem_req_next = 1'b0;
            w_mem_we_next  = 1'b0;
          end
        end
      end

      S_FETCH: begin
        if (mem_ack) begin
          w_if_done_next  = 1'b1;
          w_if_rdata_next = mem_rdata;
          w_state_next    = S_IDLE;
          w_mem_req_next  = 1'b0;
          w_mem_we_next   = 1'b0;
        end
      end

      default: begin
        w_state_next   = S_IDLE;
        w_mem_req_next = 1'b0;
        w_mem_we_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (pipe_stall && (r_stall_cnt != CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Randomized scoreboard bench for unified_mem_arbiter: a transaction-level model
// predicts memory accesses, latencies and captured data for each instruction.
module tb_unified_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        dm_read;
  logic        dm_write;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] if_rdata;
  logic [31:0] dm_rdata;
  logic        pc_write;
  logic        if_id_write;
  logic        pipe_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [15:0] stall_cnt;

  logic [31:0] s_if_rdata;
  logic [31:0] s_dm_rdata;
  logic        s_pc_write;
  logic        s_if_id_write;
  logic        s_pipe_stall;
  logic        s_mem_req;
  logic        s_mem_we;
  logic [31:0] s_mem_addr;
  logic [31:0] s_mem_wdata;
  logic [3:0]  s_stall_cnt;

  unified_mem_arbiter dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr),
    .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .if_rdata(if_rdata), .dm_rdata(dm_rdata), .pc_write(pc_write),
    .if_id_write(if_id_write), .pipe_stall(pipe_stall), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall_cnt(stall_cnt)
  );

  // Second instance against a memory that never answers, to exercise saturation.
  unified_mem_arbiter #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .if_req(1'b1), .if_addr(32'h0000_0020),
    .dm_read(1'b0), .dm_write(1'b0), .dm_addr(32'h0), .dm_wdata(32'h0),
    .if_rdata(s_if_rdata), .dm_rdata(s_dm_rdata), .pc_write(s_pc_write),
    .if_id_write(s_if_id_write), .pipe_stall(s_pipe_stall), .mem_req(s_mem_req),
    .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
    .mem_ack(1'b0), .mem_rdata(32'h0), .stall_cnt(s_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk_wdata;
  } acc_t;

  typedef struct {
    logic [31:0] ifd;
    logic [31:0] dmd;
    int          lat;
    int          stall;
  } res_t;

  acc_t acc_q[$];
  res_t res_q[$];
  int   delay_q[$];

  logic [31:0] model_mem [logic [31:0]];
  logic [31:0] phys_mem  [logic [31:0]];
  logic [31:0] model_if;
  logic [31:0] model_dm;

  int   checks = 0;
  int   errors = 0;
  int   txn_no = 0;
  logic active = 1'b0;
  logic spurious = 1'b0;

  function automatic logic [31:0] default_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) + 32'h1357_0000;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : default_word(a);
  endfunction

  function automatic logic [31:0] phys_read(input logic [31:0] a);
    return phys_mem.exists(a) ? phys_mem[a] : default_word(a);
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic finish_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  // Transaction-level model: data access (if any) precedes the fetch; each access
  // costs one cycle plus its wait states, plus one decide and one advance cycle.
  task automatic model_push(input logic ir, input logic [31:0] ia, input logic rd,
                            input logic wr, input logic [31:0] da, input logic [31:0] dw,
                            input int d0, input int d1, input logic restart);
    acc_t a;
    res_t r;
    int   n;
    int   sum;
    n   = 0;
    sum = 0;
    if (rd || wr) begin
      a.we = wr; a.addr = da; a.wdata = dw; a.chk_wdata = 1'b1;
      acc_q.push_back(a);
      delay_q.push_back(d0);
      n++; sum += d0;
      if (wr) model_mem[da] = dw;
      else    model_dm = model_read(da);
    end
    if (ir) begin
      a.we = 1'b0; a.addr = ia; a.wdata = 32'h0; a.chk_wdata = 1'b0;
      acc_q.push_back(a);
      delay_q.push_back(d1);
      n++; sum += d1;
      model_if = model_read(ia);
    end
    r.ifd   = model_if;
    r.dmd   = model_dm;
    r.lat   = (n == 0) ? 1 : 2 + n + sum;
    r.stall = r.lat - 1;
    if (restart) begin
      // Observation starts after the decide edge, which still counts as stalled.
      r.lat   = r.lat - 1;
      r.stall = r.lat;
    end
    res_q.push_back(r);
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia, input logic rd,
                       input logic wr, input logic [31:0] da, input logic [31:0] dw);
    if_req = ir; if_addr = ia; dm_read = rd; dm_write = wr; dm_addr = da; dm_wdata = dw;
  endtask

  task automatic wait_advance();
    int k;
    k = 0;
    forever begin
      @(negedge clk);
      if (pc_write) break;
      k++;
      if (k > 60) begin
        checks++; errors++;
        $display("FAIL advance_timeout: got no advance in %0d cycles, expected one", k);
        finish_run();
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input logic ir, input logic [31:0] ia, input logic rd,
                         input logic wr, input logic [31:0] da, input logic [31:0] dw,
                         input int d0, input int d1);
    model_push(ir, ia, rd, wr, da, dw, d0, d1, 1'b0);
    drive(ir, ia, rd, wr, da, dw);
    active = 1'b1;
    wait_advance();
  endtask

  // Memory responder: pops a wait count per request, checks the request against
  // the expected access order and that it is held stable while unacknowledged.
  initial begin
    logic        busy;
    int          wait_left;
    logic        h_we;
    logic [31:0] h_addr;
    logic [31:0] h_wdata;
    acc_t        e;
    busy = 1'b0; wait_left = 0; h_we = 1'b0; h_addr = '0; h_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (spurious) begin
        spurious  = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'hBAD0_0BAD;
      end else if (mem_req) begin
        if (!busy) begin
          busy = 1'b1;
          wait_left = (delay_q.size() > 0) ? delay_q.pop_front() : 0;
          h_we = mem_we; h_addr = mem_addr; h_wdata = mem_wdata;
        end else begin
          check32("mem_hold", {31'h0, mem_we} ^ mem_addr ^ mem_wdata,
                  {31'h0, h_we} ^ h_addr ^ h_wdata);
        end
        if (wait_left == 0) begin
          busy    = 1'b0;
          mem_ack = 1'b1;
          if (acc_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL mem_unexpected: got request addr %h, expected none", mem_addr);
            mem_rdata = 32'h0;
          end else begin
            e = acc_q.pop_front();
            check32("mem_we", {31'h0, mem_we}, {31'h0, e.we});
            check32("mem_addr", mem_addr, e.addr);
            if (e.chk_wdata) check32("mem_wdata", mem_wdata, e.wdata);
            if (mem_we) begin
              phys_mem[mem_addr] = mem_wdata;
              mem_rdata = $urandom;
            end else begin
              mem_rdata = phys_read(mem_addr);
            end
          end
        end else begin
          wait_left--;
        end
      end else begin
        busy = 1'b0;
      end
    end
  end

  // Monitor: every advance retires one predicted instruction.
  initial begin
    int   cyc;
    int   prev_stall;
    res_t r;
    cyc = 0; prev_stall = 0;
    forever begin
      @(negedge clk);
      if (!active) begin
        cyc = 0;
        prev_stall = int'(stall_cnt);
      end else begin
        cyc++;
        if (pc_write) begin
          if (res_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL adv_unexpected: got advance, expected none pending");
          end else begin
            r = res_q.pop_front();
            txn_no++;
            $display("txn %0d lat %0d if_rdata %h dm_rdata %h stall_cnt %0d",
                     txn_no, cyc, if_rdata, dm_rdata, stall_cnt);
            check32("latency", 32'(cyc), 32'(r.lat));
            check32("if_rdata", if_rdata, r.ifd);
            check32("dm_rdata", dm_rdata, r.dmd);
            check32("stall_delta", 32'(int'(stall_cnt) - prev_stall), 32'(r.stall));
            check32("if_id_write", {31'h0, if_id_write}, 32'h1);
            check32("pipe_stall", {31'h0, pipe_stall}, 32'h0);
          end
          cyc = 0;
          prev_stall = int'(stall_cnt);
        end
      end
    end
  end

  initial begin
    logic        ir;
    logic        rd;
    logic        wr;
    logic [31:0] ia;
    logic [31:0] da;
    logic [31:0] dw;
    int          k;
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    model_if = 32'h0;
    model_dm = 32'h0;
    model_mem[32'h10] = 32'h2002_0005;
    phys_mem[32'h10]  = 32'h2002_0005;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check32("rst_mem_req", {31'h0, mem_req}, 32'h0);
    check32("rst_mem_addr", mem_addr, 32'h0);
    check32("rst_if_rdata", if_rdata, 32'h0);
    check32("rst_dm_rdata", dm_rdata, 32'h0);
    check32("rst_stall_cnt", {16'h0, stall_cnt}, 32'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Directed: fetch only, fetch with load, store with slow memory then fetch.
    run_txn(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 0, 0);
    run_txn(1'b1, 32'h80, 1'b1, 1'b0, 32'h40, 32'h0, 0, 0);
    run_txn(1'b1, 32'h84, 1'b0, 1'b1, 32'h44, 32'hDEAD_BEEF, 3, 0);
    run_txn(1'b1, 32'h44, 1'b1, 1'b0, 32'h44, 32'h0, 1, 2);

    // Spurious acknowledge while idle must change nothing.
    active = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    spurious = 1'b1;
    repeat (3) @(negedge clk);
    check32("spur_mem_req", {31'h0, mem_req}, 32'h0);
    check32("spur_if_rdata", if_rdata, model_if);
    check32("spur_dm_rdata", dm_rdata, model_dm);
    check32("spur_stall", {31'h0, pipe_stall}, 32'h0);
    @(posedge clk);
    #1;
    run_txn(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 0, 0);

    // Reset in the middle of a data access, then release and let it re-issue.
    active = 1'b0;
    delay_q.push_back(6);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h48, 32'h0);
    k = 0;
    while (!mem_req) begin
      @(negedge clk);
      k++;
      if (k > 10) begin
        checks++; errors++;
        $display("FAIL rst_req_timeout: got mem_req=0, expected 1");
        finish_run();
      end
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    check32("rst_async_req", {31'h0, mem_req}, 32'h0);
    check32("rst_async_cnt", {16'h0, stall_cnt}, 32'h0);
    model_if = 32'h0;
    model_dm = 32'h0;
    model_push(1'b0, 32'h0, 1'b1, 1'b0, 32'h48, 32'h0, 0, 0, 1'b1);
    @(negedge clk);
    #1;
    rst = 1'b1;
    active = 1'b1;
    wait_advance();

    // Randomized instruction stream.
    for (int t = 0; t < 150; t++) begin
      ir = ($urandom_range(0, 9) != 0);
      k  = $urandom_range(0, 3);
      rd = (k == 1) || (k == 3);
      wr = (k == 2) || (k == 3);
      ia = 32'($urandom_range(0, 31)) * 32'd4;
      da = 32'($urandom_range(0, 31)) * 32'd4;
      dw = $urandom;
      run_txn(ir, ia, rd, wr, da, dw,
              ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0,
              ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
    end

    active = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    check32("res_q_empty", 32'(res_q.size()), 32'h0);
    check32("acc_q_empty", 32'(acc_q.size()), 32'h0);
    check32("sat_cnt_a", {28'h0, s_stall_cnt}, 32'd15);
    repeat (3) @(negedge clk);
    check32("sat_cnt_b", {28'h0, s_stall_cnt}, 32'd15);
    check32("sat_stall", {31'h0, s_pipe_stall}, 32'h1);
    finish_run();
  end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one external single-port memory between the pipeline's instruction fetch (IF) and data access (MEM) stages.
- Sequences the accesses with a small FSM and holds their results in registers.
- Generates the global pipeline freeze: PCWrite, IF_ID_Write and pipe_stall for ID/EX, EX/MEM and MEM/WB.
- Sits beside the datapath. It replaces the separate instruction and data memory ports with a request/ack interface toward the memory.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
CNT_W, 16, width of the saturating stall-cycle counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
if_req  in  1  fetch needed this pipeline cycle (tied high in normal operation)
if_addr  in  ADDR_W  fetch address (PC-mux output); stable while pipe_stall=1
dm_read  in  1  EX/MEM MemRead
dm_write  in  1  EX/MEM MemWrite
dm_addr  in  ADDR_W  EX/MEM ALU result
dm_wdata  in  DATA_W  EX/MEM write data
if_rdata  out  DATA_W  registered fetched instruction
dm_rdata  out  DATA_W  registered load data
pc_write  out  1  PC enable (= ~pipe_stall)
if_id_write  out  1  IF/ID enable (= ~pipe_stall)
pipe_stall  out  1  freeze all pipeline registers
mem_req  out  1  memory request, registered
mem_we  out  1  memory write enable, registered
mem_addr  out  ADDR_W  memory address, registered
mem_wdata  out  DATA_W  memory write data, registered
mem_ack  in  1  one-cycle completion pulse; mem_rdata valid in the same cycle
mem_rdata  in  DATA_W  memory read data
stall_cnt  out  CNT_W  saturating count of cycles with pipe_stall=1

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - if_rdata=0, dm_rdata=0; flags if_done=0, dm_done=0; stall_cnt=0.
  - Reset mid-transaction abandons the access immediately. The memory must drop an unacked request when mem_req falls.
- Derived signals:
  - dm_need = dm_read | dm_write.
  - advance = (~dm_need | dm_done) & (~if_req | if_done), computed from registered flags.
  - pipe_stall = ~advance; pc_write = if_id_write = advance.
- Clearing on advance: if_done and dm_done clear on the next edge. The registered if_rdata/dm_rdata keep their values until overwritten.
- FSM states: IDLE, DATA, FETCH.
  - IDLE, dm_need & ~dm_done: -> DATA. Load mem_req=1, mem_we=dm_write, mem_addr=dm_addr, mem_wdata=dm_wdata.
  - IDLE, otherwise if_req & ~if_done & ~advance: -> FETCH. Load mem_req=1, mem_we=0, mem_addr=if_addr.
  - IDLE, otherwise: stay, mem_req=0.
  - DATA, mem_ack: dm_done<=1. If the access is a read, dm_rdata<=mem_rdata. Then:
    - if if_req & ~if_done: -> FETCH, next cycle's mem_req=1, mem_addr=if_addr.
    - else -> IDLE, mem_req=0.
  - FETCH, mem_ack: if_done<=1, if_rdata<=mem_rdata, -> IDLE, mem_req=0.
  - DATA or FETCH without mem_ack: hold all mem_* outputs stable.
- Priority: data before fetch, because the older instruction goes first.
- dm_read & dm_write both high: illegal; treated as a write.
- mem_ack in IDLE is ignored; no state change.
- Latency (ack in the first cycle of mem_req):
  - Fetch-only instruction: 3 cycles per advance (decide, req+ack, advance).
  - Fetch plus data access: 4 cycles.
  - Each extra memory wait cycle adds 1.
- stall_cnt: +1 on every cycle with pipe_stall=1; saturates at 2^CNT_W-1; no wrap.
- Inputs from the pipeline registers are stable while pipe_stall=1, since those registers are frozen. The arbiter does not re-sample them mid-access beyond the issue cycle.

Test Plan:
- Reset, then if_req=1, if_addr=0x0000_0010, memory acks on the first req cycle with 0x2002_0005 -> mem_req high in cycle 1 only; if_rdata=0x2002_0005; advance=1 in cycle 2; stall_cnt=2.
- dm_read=1, dm_addr=0x40, if_req=1 -> first access has mem_we=0, mem_addr=0x40; dm_rdata captured; second access is the fetch; advance 4 cycles after start.
- dm_write=1, dm_addr=0x44, dm_wdata=0xDEAD_BEEF, memory delays ack by 3 cycles -> mem_we, mem_addr and mem_wdata held constant throughout; pipe_stall=1 until the cycle after the fetch ack.
- Spurious mem_ack in IDLE -> no state change; if_done and dm_done unchanged.
- rst asserted during DATA with mem_req=1 -> mem_req=0 asynchronously; after release, the FSM restarts from IDLE and re-issues the data access.
- CNT_W=4 with a memory that never acks -> stall_cnt saturates at 15 and holds.
